// File: rtl/lsu_sbuf.sv
// lsu_sbuf: load/store unit with a write-back store buffer.
// Stores retire into a circular FIFO that drains to mem_ctrl in the background.
// Loads go through a registered request FSM (IDLE/DRAIN/LOAD/LDONE).
// Non-memory instructions pass through combinationally.
// Optional feature macro: LSU_STORE_FWD_EN enables store-to-load forwarding.
// Without it, every load waits for the buffer to empty before it issues.
module lsu_sbuf #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SB_DEPTH   = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  valid_in,
  input  logic                  load_in,
  input  logic                  store_in,
  input  logic [1:0]            size_in,
  input  logic                  unsigned_in,
  input  logic [ADDR_WIDTH-1:0] mem_addr_in,
  input  logic [DATA_WIDTH-1:0] mem_val_in,
  input  logic                  rd_in,
  input  logic [4:0]            rd_addr_in,
  input  logic [DATA_WIDTH-1:0] rd_val_in,
  output logic                  rd_out,
  output logic [4:0]            rd_addr_out,
  output logic [DATA_WIDTH-1:0] rd_val_out,
  output logic                  stall_req_out,
  output logic                  read_req_out,
  output logic                  write_req_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic [DATA_WIDTH-1:0] mem_val_out,
  output logic [2:0]            store_len_out,
  input  logic                  mem_done_in,
  input  logic [DATA_WIDTH-1:0] mem_val_read_in,
  input  logic [1:0]            memctrl_busy_in,
  output logic                  sb_empty_out
);

  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    LOAD  = 2'd2,
    LDONE = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] sbAddr_q [SB_DEPTH];
  logic [DATA_WIDTH-1:0] sbData_q [SB_DEPTH];
  logic [1:0]            sbSize_q [SB_DEPTH];

  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] loadData_q, loadData_d;

  logic                  loadReq;
  logic                  push;
  logic                  pop;
  logic                  fwdHit;
  logic                  canIssue;
  logic [DATA_WIDTH-1:0] fwdData;
  logic                  stallStore;
  logic                  stallLoad;

  // Only bit1 of the busy bus matters here; bit0 is carried for mem_ctrl symmetry.
  logic unusedBusy;
  assign unusedBusy = memctrl_busy_in[0];

  // Sign/zero extension of low-aligned load data by access size.
  function automatic logic [DATA_WIDTH-1:0] extendLoad(
    input logic [DATA_WIDTH-1:0] raw,
    input logic [1:0]            sz,
    input logic                  uns
  );
    logic [DATA_WIDTH-1:0] res;
    case (sz)
      2'd0:    res = uns ? {{(DATA_WIDTH-8){1'b0}}, raw[7:0]}
                         : {{(DATA_WIDTH-8){raw[7]}}, raw[7:0]};
      2'd1:    res = uns ? {{(DATA_WIDTH-16){1'b0}}, raw[15:0]}
                         : {{(DATA_WIDTH-16){raw[15]}}, raw[15:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

  // Byte-lane length code handed to mem_ctrl.
  function automatic logic [2:0] lenCode(input logic [1:0] sz);
    logic [2:0] res;
    case (sz)
      2'd0:    res = 3'b000;
      2'd1:    res = 3'b001;
      default: res = 3'b011;
    endcase
    return res;
  endfunction

  assign loadReq    = valid_in & load_in;
  assign push       = valid_in & store_in & (count_q < CW'(SB_DEPTH));
  assign pop        = (state_q == DRAIN) & mem_done_in;
  assign stallStore = valid_in & store_in & (count_q == CW'(SB_DEPTH));
  assign stallLoad  = loadReq & ~fwdHit & (state_q != LDONE);

`ifdef LSU_STORE_FWD_EN
  logic          fwdMatch;
  logic [PW-1:0] fwdIdx;

  // Scan oldest to youngest so the last word-address match is the youngest entry.
  always_comb begin
    logic [PW-1:0] idx;
    fwdMatch = 1'b0;
    fwdIdx   = '0;
    idx      = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) &&
          (sbAddr_q[idx][ADDR_WIDTH-1:2] == mem_addr_in[ADDR_WIDTH-1:2])) begin
        fwdMatch = 1'b1;
        fwdIdx   = idx;
      end
    end
  end

  assign fwdHit   = loadReq & fwdMatch & (sbAddr_q[fwdIdx] == mem_addr_in) &
                    (sbSize_q[fwdIdx] >= size_in);
  assign canIssue = ~fwdMatch;
  assign fwdData  = extendLoad(sbData_q[fwdIdx], size_in, unsigned_in);
`else
  assign fwdHit   = 1'b0;
  assign canIssue = (count_q == '0);
  assign fwdData  = '0;
`endif

  // Next-state logic: a ready load wins over draining, both need mem_ctrl free.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (loadReq && !fwdHit && canIssue && !memctrl_busy_in[1]) begin
          state_d = LOAD;
        end else if ((count_q != '0) && !memctrl_busy_in[1]) begin
          state_d = DRAIN;
        end
      end
      DRAIN:   if (mem_done_in) state_d = IDLE;
      LOAD:    if (mem_done_in) state_d = LDONE;
      LDONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pointer, occupancy and load-capture next values; push and pop may coincide.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    loadData_d = loadData_q;
    if (push) tail_d = tail_q + PW'(1);
    if (pop)  head_d = head_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if ((state_q == LOAD) && mem_done_in) begin
      loadData_d = extendLoad(mem_val_read_in, size_in, unsigned_in);
    end
  end

  // Control registers; reset discards every buffered store.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      loadData_q <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      loadData_q <= loadData_d;
    end
  end

  // Entry storage is only meaningful below count, so it needs no reset.
  always_ff @(posedge clk_in) begin
    if (push) begin
      sbAddr_q[tail_q] <= mem_addr_in;
      sbData_q[tail_q] <= mem_val_in;
      sbSize_q[tail_q] <= size_in;
    end
  end

  // Output decode; reset forces every output low immediately.
  always_comb begin
    rd_out        = 1'b0;
    rd_addr_out   = '0;
    rd_val_out    = '0;
    stall_req_out = 1'b0;
    read_req_out  = 1'b0;
    write_req_out = 1'b0;
    mem_addr_out  = '0;
    mem_val_out   = '0;
    store_len_out = '0;
    if (!rst_in) begin
      stall_req_out = stallStore | stallLoad;
      case (state_q)
        DRAIN: begin
          write_req_out = 1'b1;
          mem_addr_out  = sbAddr_q[head_q];
          mem_val_out   = sbData_q[head_q];
          store_len_out = lenCode(sbSize_q[head_q]);
        end
        LOAD: begin
          read_req_out = 1'b1;
          mem_addr_out = mem_addr_in;
        end
        default: ;
      endcase
      if (state_q == LDONE) begin
        rd_out      = 1'b1;
        rd_addr_out = rd_addr_in;
        rd_val_out  = loadData_q;
      end else if (fwdHit) begin
        rd_out      = 1'b1;
        rd_addr_out = rd_addr_in;
        rd_val_out  = fwdData;
      end else if (!(stallStore | stallLoad)) begin
        rd_out      = rd_in;
        rd_addr_out = rd_addr_in;
        rd_val_out  = rd_val_in;
      end
    end
  end

  assign sb_empty_out = (count_q == '0);

endmodule

// File: tb/tb_lsu_sbuf.sv
// tb_lsu_sbuf: self-checking bench for lsu_sbuf with a scoreboard of expected
// memory writes and load results, plus a small mem_ctrl responder.
module tb_lsu_sbuf;

  logic        clk_in;
  logic        rst_in;
  logic        valid_in;
  logic        load_in;
  logic        store_in;
  logic [1:0]  size_in;
  logic        unsigned_in;
  logic [31:0] mem_addr_in;
  logic [31:0] mem_val_in;
  logic        rd_in;
  logic [4:0]  rd_addr_in;
  logic [31:0] rd_val_in;
  logic        rd_out;
  logic [4:0]  rd_addr_out;
  logic [31:0] rd_val_out;
  logic        stall_req_out;
  logic        read_req_out;
  logic        write_req_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_val_out;
  logic [2:0]  store_len_out;
  logic        mem_done_in;
  logic [31:0] mem_val_read_in;
  logic [1:0]  memctrl_busy_in;
  logic        sb_empty_out;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  len;
  } wr_t;

  wr_t         wrQ[$];
  logic [31:0] rdQ[$];

  int checkCount = 0;
  int errCount   = 0;

  lsu_sbuf #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SB_DEPTH(4)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .valid_in        (valid_in),
    .load_in         (load_in),
    .store_in        (store_in),
    .size_in         (size_in),
    .unsigned_in     (unsigned_in),
    .mem_addr_in     (mem_addr_in),
    .mem_val_in      (mem_val_in),
    .rd_in           (rd_in),
    .rd_addr_in      (rd_addr_in),
    .rd_val_in       (rd_val_in),
    .rd_out          (rd_out),
    .rd_addr_out     (rd_addr_out),
    .rd_val_out      (rd_val_out),
    .stall_req_out   (stall_req_out),
    .read_req_out    (read_req_out),
    .write_req_out   (write_req_out),
    .mem_addr_out    (mem_addr_out),
    .mem_val_out     (mem_val_out),
    .store_len_out   (store_len_out),
    .mem_done_in     (mem_done_in),
    .mem_val_read_in (mem_val_read_in),
    .memctrl_busy_in (memctrl_busy_in),
    .sb_empty_out    (sb_empty_out)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Global time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic l, input logic s,
                               input logic [1:0] sz, input logic u,
                               input logic [31:0] addr, input logic [31:0] val);
    valid_in    = v;
    load_in     = l;
    store_in    = s;
    size_in     = sz;
    unsigned_in = u;
    mem_addr_in = addr;
    mem_val_in  = val;
  endtask

  // Wait for a drain request, hold it for a few cycles, compare with the queue head, then complete it.
  task automatic serviceWrite(input string tag, input int holdCycles);
    int  n;
    wr_t e;
    n = 0;
    while (!write_req_out && n < 40) begin
      checkOutput({tag, "_noRead"}, read_req_out, 0);
      @(negedge clk_in);
      n++;
    end
    checkOutput({tag, "_writeReq"}, write_req_out, 1);
    if (write_req_out) begin
      for (int k = 0; k < holdCycles; k++) begin
        @(negedge clk_in);
        checkOutput({tag, "_hold"}, write_req_out, 1);
      end
      checkOutput({tag, "_qDepth"}, (wrQ.size() > 0), 1);
      if (wrQ.size() > 0) begin
        e = wrQ.pop_front();
        checkOutput({tag, "_addr"}, mem_addr_out, e.addr);
        checkOutput({tag, "_data"}, mem_val_out, e.data);
        checkOutput({tag, "_len"}, store_len_out, e.len);
      end
      mem_done_in = 1'b1;
      @(negedge clk_in);
      mem_done_in = 1'b0;
      #1;
    end
  endtask

  // Wait for a read request, return data, then compare the LDONE writeback with the queue head.
  task automatic serviceRead(input string tag, input logic [31:0] addr, input logic [31:0] rdata,
                             input logic [4:0] rdAddr, output int lat);
    int          n;
    logic [31:0] e;
    n = 0;
    while (!read_req_out && n < 40) begin
      @(negedge clk_in);
      n++;
    end
    lat = n;
    checkOutput({tag, "_readReq"}, read_req_out, 1);
    if (read_req_out) begin
      checkOutput({tag, "_addr"}, mem_addr_out, addr);
      checkOutput({tag, "_stall"}, stall_req_out, 1);
      mem_val_read_in = rdata;
      mem_done_in     = 1'b1;
      @(negedge clk_in);
      mem_done_in     = 1'b0;
      mem_val_read_in = '0;
      #1;
      checkOutput({tag, "_rdOut"}, rd_out, 1);
      checkOutput({tag, "_release"}, stall_req_out, 0);
      checkOutput({tag, "_rdAddr"}, rd_addr_out, rdAddr);
      checkOutput({tag, "_qDepth"}, (rdQ.size() > 0), 1);
      if (rdQ.size() > 0) begin
        e = rdQ.pop_front();
        checkOutput({tag, "_rdVal"}, rd_val_out, e);
      end
    end
  endtask

  initial begin
    int  lat;
    int  n;
    wr_t fifth;

    rst_in          = 1'b1;
    mem_done_in     = 1'b0;
    mem_val_read_in = '0;
    memctrl_busy_in = 2'b00;
    applyStimulus(1, 0, 0, 0, 0, 32'h0, 32'h0);
    rd_in      = 1'b1;
    rd_addr_in = 5'd9;
    rd_val_in  = 32'h55;
    #1;
    checkOutput("rstRdOut", rd_out, 0);
    checkOutput("rstRdVal", rd_val_out, 0);
    checkOutput("rstStall", stall_req_out, 0);
    checkOutput("rstWrite", write_req_out, 0);
    checkOutput("rstRead", read_req_out, 0);
    checkOutput("rstEmpty", sb_empty_out, 1);

    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    checkOutput("passRd", rd_out, 1);
    checkOutput("passAddr", rd_addr_out, 9);
    checkOutput("passVal", rd_val_out, 32'h55);
    checkOutput("passStall", stall_req_out, 0);
    rd_in = 1'b0;

    // Single store, drained with mem_done held off for one extra cycle.
    @(negedge clk_in);
    applyStimulus(1, 0, 1, 2, 0, 32'h100, 32'hDEADBEEF);
    #1;
    checkOutput("swStall", stall_req_out, 0);
    wrQ.push_back('{32'h100, 32'hDEADBEEF, 3'b011});
    @(negedge clk_in);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
    #1;
    checkOutput("swNotEmpty", sb_empty_out, 0);
    serviceWrite("swDrain", 1);
    checkOutput("swEmpty", sb_empty_out, 1);

    // Fill the buffer while mem_ctrl is busy; the fifth store stalls.
    memctrl_busy_in = 2'b10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      applyStimulus(1, 0, 1, 2, 0, 32'h400 + 32'(4 * i), 32'hA000_0000 + 32'(i));
      #1;
      checkOutput($sformatf("fillStall%0d", i), stall_req_out, (i == 4));
      if (i < 4) wrQ.push_back('{32'h400 + 32'(4 * i), 32'hA000_0000 + 32'(i), 3'b011});
    end
    fifth = '{32'h410, 32'hA000_0004, 3'b011};
    rd_in = 1'b1;
    @(negedge clk_in);
    #1;
    checkOutput("fullHold", stall_req_out, 1);
    checkOutput("fullRdOut", rd_out, 0);
    checkOutput("busyNoWrite", write_req_out, 0);
    memctrl_busy_in = 2'b00;
    serviceWrite("fullDrain0", 0);
    checkOutput("fifthAccept", stall_req_out, 0);
    wrQ.push_back(fifth);
    @(negedge clk_in);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
    rd_in = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) serviceWrite($sformatf("fullDrain%0d", i + 1), 0);
    checkOutput("fullEmpty", sb_empty_out, 1);

    // Loads from memory with each extension mode.
    @(negedge clk_in);
    applyStimulus(1, 1, 0, 0, 0, 32'h203, 32'h0);
    rd_addr_in = 5'd3;
    #1;
    checkOutput("lbStall", stall_req_out, 1);
    checkOutput("lbNoReqYet", read_req_out, 0);
    rdQ.push_back(32'hFFFF_FFF0);
    serviceRead("lb", 32'h203, 32'h0000_00F0, 5'd3, lat);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
    checkOutput("lbLatency", lat, 1);

    @(negedge clk_in);
    applyStimulus(1, 1, 0, 0, 1, 32'h203, 32'h0);
    rdQ.push_back(32'h0000_00F0);
    #1;
    serviceRead("lbu", 32'h203, 32'h0000_00F0, 5'd3, lat);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);

    @(negedge clk_in);
    applyStimulus(1, 1, 0, 1, 0, 32'h206, 32'h0);
    rd_addr_in = 5'd5;
    rdQ.push_back(32'hFFFF_8001);
    #1;
    serviceRead("lh", 32'h206, 32'h0000_8001, 5'd5, lat);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);

    @(negedge clk_in);
    applyStimulus(1, 1, 0, 2, 0, 32'h208, 32'h0);
    rdQ.push_back(32'h89AB_CDEF);
    #1;
    serviceRead("lw", 32'h208, 32'h89AB_CDEF, 5'd5, lat);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);

    // Buffered word store followed by a half load of the same address.
    memctrl_busy_in = 2'b10;
    @(negedge clk_in);
    applyStimulus(1, 0, 1, 2, 0, 32'h300, 32'h1234_5678);
    wrQ.push_back('{32'h300, 32'h1234_5678, 3'b011});
    @(negedge clk_in);
    applyStimulus(1, 1, 0, 1, 0, 32'h300, 32'h0);
    rd_addr_in = 5'd4;
    #1;
`ifdef LSU_STORE_FWD_EN
    checkOutput("fwdRdOut", rd_out, 1);
    checkOutput("fwdRdVal", rd_val_out, 32'h0000_5678);
    checkOutput("fwdRdAddr", rd_addr_out, 4);
    checkOutput("fwdStall", stall_req_out, 0);
    checkOutput("fwdNoRead", read_req_out, 0);
    @(negedge clk_in);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
    memctrl_busy_in = 2'b00;
    #1;
    serviceWrite("fwdDrain", 0);
`else
    checkOutput("noFwdStall", stall_req_out, 1);
    rdQ.push_back(32'h0000_5678);
    @(negedge clk_in);
    #1;
    checkOutput("noFwdWait", read_req_out, 0);
    memctrl_busy_in = 2'b00;
    serviceWrite("noFwdDrain", 0);
    serviceRead("noFwdLoad", 32'h300, 32'h1234_5678, 5'd4, lat);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
`endif

    // Byte store that does not cover a word load: the load waits for the drain.
    memctrl_busy_in = 2'b10;
    @(negedge clk_in);
    applyStimulus(1, 0, 1, 0, 0, 32'h301, 32'h0000_00AB);
    wrQ.push_back('{32'h301, 32'h0000_00AB, 3'b000});
    @(negedge clk_in);
    applyStimulus(1, 1, 0, 2, 0, 32'h300, 32'h0);
    rd_addr_in = 5'd6;
    rdQ.push_back(32'hA5A5_A5A5);
    #1;
    checkOutput("partStall", stall_req_out, 1);
    checkOutput("partRdOut", rd_out, 0);
    @(negedge clk_in);
    #1;
    checkOutput("partWait", read_req_out, 0);
    memctrl_busy_in = 2'b00;
    serviceWrite("partDrain", 0);
    serviceRead("partLoad", 32'h300, 32'hA5A5_A5A5, 5'd6, lat);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);

    // Reset in the middle of a drain with three entries buffered.
    memctrl_busy_in = 2'b10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      applyStimulus(1, 0, 1, 2, 0, 32'h500 + 32'(4 * i), 32'hC000_0000 + 32'(i));
    end
    @(negedge clk_in);
    applyStimulus(1, 0, 0, 0, 0, 32'h0, 32'h0);
    rd_in           = 1'b1;
    memctrl_busy_in = 2'b00;
    n = 0;
    while (!write_req_out && n < 40) begin
      @(negedge clk_in);
      n++;
    end
    checkOutput("preRstDrain", write_req_out, 1);
    #2;
    rst_in = 1'b1;
    #1;
    checkOutput("midRstWrite", write_req_out, 0);
    checkOutput("midRstAddr", mem_addr_out, 0);
    checkOutput("midRstData", mem_val_out, 0);
    checkOutput("midRstLen", store_len_out, 0);
    checkOutput("midRstRdOut", rd_out, 0);
    checkOutput("midRstEmpty", sb_empty_out, 1);
    @(negedge clk_in);
    rst_in = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
    rd_in = 1'b0;
    @(negedge clk_in);
    #1;
    checkOutput("postRstWrite", write_req_out, 0);
    checkOutput("postRstRead", read_req_out, 0);
    checkOutput("postRstEmpty", sb_empty_out, 1);

    // Buffer works again after reset; half store uses length 001.
    @(negedge clk_in);
    applyStimulus(1, 0, 1, 1, 0, 32'h600, 32'h0000_BEEF);
    wrQ.push_back('{32'h600, 32'h0000_BEEF, 3'b001});
    @(negedge clk_in);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
    #1;
    serviceWrite("postRstStore", 0);
    checkOutput("finalEmpty", sb_empty_out, 1);

    checkOutput("wrQLeft", wrQ.size(), 0);
    checkOutput("rdQLeft", rdQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
